// File: rtl/pad_pkg.sv
// pad_pkg: shared FSM state type and widths for the controller-pad responder
package pad_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} padState_t;
    localparam int BIT_CNT_W = 4;
    localparam int POLL_W = 16;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);
endpackage

// File: rtl/pad_sync_edge.sv
// pad_sync_edge: multi-flop synchronizer with a history flop reporting level and change pulses
module pad_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic changed
);
    logic [STAGES-1:0] sync;
    logic hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], pad};
            hist <= sync[STAGES-1];
        end
    end
    assign level = sync[STAGES-1];
    assign changed = sync[STAGES-1] ^ hist;
endmodule

// File: rtl/pad_responder.sv
// pad_responder: serial game-pad responder; latches buttons on padLATCH and shifts them out on padCLK
module pad_responder
    import pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              padLATCH,
    input  logic              padCLK,
    input  logic [7:0]        buttons,
    output logic              padDATA,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [POLL_W-1:0] poll_count
);
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic latchLvl, latchChg, clkLvl, clkChg;
    logic latchRise, latchFall, clkRise;
    padState_t state;
    logic [7:0] shreg;
    logic [BIT_CNT_W-1:0] bitCnt;
    logic [TO_W-1:0] toCnt;
    pad_sync_edge #(.STAGES(SYNC_STAGES)) latchSync (
        .clk(PCLK), .rst(RESET), .pad(padLATCH), .level(latchLvl), .changed(latchChg)
    );
    pad_sync_edge #(.STAGES(SYNC_STAGES)) clkSync (
        .clk(PCLK), .rst(RESET), .pad(padCLK), .level(clkLvl), .changed(clkChg)
    );
    assign latchRise = latchChg & latchLvl;
    assign latchFall = latchChg & ~latchLvl;
    assign clkRise = clkChg & clkLvl;
    assign padDATA = ~shreg[0];
    // A latch rising edge pre-empts everything, including a coincident shift clock.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            shreg <= '0;
            bitCnt <= '0;
            toCnt <= '0;
            frame_done <= 1'b0;
            timeout_err <= 1'b0;
            poll_count <= '0;
        end else begin
            frame_done <= 1'b0;
            timeout_err <= 1'b0;
            if (latchRise) begin
                state <= LOAD;
                shreg <= buttons;
                bitCnt <= '0;
                toCnt <= '0;
                poll_count <= poll_count + 1'b1;
            end else begin
                case (state)
                    LOAD: begin
                        shreg <= buttons;
                        if (latchFall) state <= SHIFT;
                    end
                    SHIFT: begin
                        if (clkRise) begin
                            shreg <= shreg >> 1;
                            bitCnt <= bitCnt + 1'b1;
                            toCnt <= '0;
                            if (bitCnt == LAST_BIT) begin
                                frame_done <= 1'b1;
                                state <= DONE;
                            end
                        end else if (toCnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            shreg <= '0;
                            toCnt <= '0;
                            state <= IDLE;
                        end else begin
                            toCnt <= toCnt + 1'b1;
                        end
                    end
                    DONE: if (clkRise) shreg <= shreg >> 1;
                    default: ;
                endcase
            end
        end
    end
endmodule
